ib_fifo: RTL and testbench
==========================

# ib_fifo

Per-port input buffer of the router datapath, directly upstream of the 2:1 output mux. Accepts flits from an input link, stores them in a small FIFO, presents the oldest flit to the mux as `odata`/`ovalid`/`ovch`, and returns one credit per dequeued flit. It also tracks packet boundaries and holds a per-packet output-port request (`oport`), which the arbiter turns into the mux `sel`.

## Interface
- `DATAW`, 66, flit width; bits [65:64] carry the flit type, [63:0] the payload.
- `VCHW`, 1, virtual-channel id width.
- `DEPTH`, 4, FIFO entries; power of two, minimum 2.
- `PORTW`, 1, output-port request width; taken from head-flit payload bits [PORTW-1:0].
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `idata`  in  DATAW  incoming flit.
- `ivalid`  in  1  incoming flit valid.
- `ivch`  in  VCHW  incoming flit VC id.
- `odata`  out  DATAW  FIFO head flit, to the mux `idata_n`.
- `ovalid`  out  1  FIFO non-empty, to the mux `ivalid_n`.
- `ovch`  out  VCHW  VC id of the head flit, to the mux `ivch_n`.
- `ordy`  in  1  downstream accepts the head flit this cycle.
- `ocredit`  out  1  one-cycle pulse per dequeued flit, returned upstream.
- `oreq`  out  1  a packet is in progress or its head is at the FIFO head.
- `oport`  out  PORTW  requested output port for the current packet.
- `ocount`  out  log2(DEPTH)+1  current occupancy.
- `oerr`  out  1  sticky error flag; only with `IB_ERR_CHECK_EN`.

## Operation
- Storage: DEPTH×(DATAW+VCHW) register array with read/write pointers of log2(DEPTH)+1 bits; the extra bit distinguishes full from empty. Pointers wrap modulo 2·DEPTH.
- Write: when `ivalid` is high and the FIFO is not full, store {`ivch`, `idata`}. Type is not checked on write.
- Read: when `ovalid` and `ordy` are both high, pop. `ordy` while empty has no effect.
- Simultaneous read and write: both occur and `ocount` is unchanged. When full, a write is accepted only if a read happens in the same cycle; otherwise the flit is dropped.
- Packet FSM, two states:
  - IDLE: `oreq` is 0 unless the head flit type is `TYPE_HEAD`. In that case `oreq` is 1 and `oport` = head payload[PORTW-1:0], taken combinationally from the stored flit.
  - On a pop of a HEAD, the FSM goes to ACTIVE and `oport` is latched into a register.
  - ACTIVE: `oreq` is 1 and `oport` holds the latched value, including while the FIFO is empty mid-packet.
  - On a pop of a TAIL, the FSM returns to IDLE.
  - A DATA or TAIL popped while IDLE is passed through; the state stays IDLE.
  - A HEAD popped while ACTIVE re-latches `oport` and the state stays ACTIVE.
- `TYPE_NONE` flits with `ivalid` high are stored and forwarded like data flits; they do not change the FSM.

## Timing
- Reset: pointers 0, FSM IDLE, and the latched `oport` register 0. As a result all outputs are 0 in the cycle after reset: `odata`, `ovalid`, `ovch`, `ocredit`, `oreq`, `oport`, `ocount`, `oerr`.
- Reset mid-packet discards all stored flits; no credits are issued for them.
- Latency: a flit written at edge N appears on `odata`/`ovalid` after edge N, i.e. 1 cycle into an empty FIFO.
- `ovalid`, `odata`, `ovch` and `ocount` decode directly from registers; there is no combinational path from `idata`/`ivalid`.
- `ocredit` is registered: a pop at edge N gives `ocredit` high for the cycle after edge N.
- Back-to-back: one pop per cycle is sustainable, giving full throughput with `ordy` held high.

## Configuration
- `IB_ERR_CHECK_EN` defined: `oerr` sets on any of the following and clears only on `rst`:
  - a write dropped because the FIFO is full;
  - a DATA or TAIL popped in IDLE;
  - a HEAD popped in ACTIVE.
- `IB_ERR_CHECK_EN` undefined: `oerr` is tied to 0 and no checking logic is generated. Datapath behaviour is identical in both builds.

## Test plan
- Reset then idle: `rst` high for 2 cycles → every output 0; `ovalid` stays 0 with `ivalid` low for 10 cycles.
- Single packet: HEAD with payload 64'h09, then 20 DATA flits, then a TAIL, with `ordy` high throughout.
  - `ovalid` rises 1 cycle after the HEAD write.
  - `oport`=1 from the HEAD through the TAIL pop.
  - Exactly 22 `ocredit` pulses; `oreq` is 0 after the TAIL pop.
- Fill and stall: write 4 flits with `ordy` low → `ocount`=4. A 5th write is dropped, `ocount` stays 4, and `oerr`=1 with the macro defined.
- Full with simultaneous read/write: at `ocount`=4 with `ordy` high and `ivalid` high → flit accepted, `ocount` stays 4, `oerr` stays 0.
- Mid-packet underrun: HEAD with payload 64'h04 and 2 DATA flits popped, then 5 empty cycles, then the TAIL → `oreq`=1 and `oport`=0 hold through the gap, then fall after the TAIL pop.
- Reset mid-packet: `rst` asserted with 3 flits stored in ACTIVE → next cycle `ocount`=0, FSM IDLE, no `ocredit` pulses.

Source files
------------

// File: rtl/ib_fifo.sv
// ib_fifo: per-port input buffer with packet-boundary tracking and per-packet output-port request.
// Latency 1 cycle from write to head, registered ocredit; full-and-not-popping drops the write. Error checker under IB_ERR_CHECK_EN.
module ib_fifo #(
    parameter int DATAW = 66,
    parameter int VCHW  = 1,
    parameter int DEPTH = 4,
    parameter int PORTW = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATAW-1:0]         idata,
    input  logic                     ivalid,
    input  logic [VCHW-1:0]          ivch,
    output logic [DATAW-1:0]         odata,
    output logic                     ovalid,
    output logic [VCHW-1:0]          ovch,
    input  logic                     ordy,
    output logic                     ocredit,
    output logic                     oreq,
    output logic [PORTW-1:0]         oport,
    output logic [$clog2(DEPTH):0]   ocount,
    output logic                     oerr
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = VCHW + DATAW;
    localparam logic [AW:0] PTR_ONE   = {{AW{1'b0}}, 1'b1};
    localparam logic [1:0]  TYPE_HEAD = 2'd1;
    localparam logic [1:0]  TYPE_TAIL = 2'd3;

    typedef enum logic {S_IDLE, S_ACTIVE} state_t;

    logic [EW-1:0]    mem_q [DEPTH];
    logic [AW:0]      wptr_q, wptr_d, rptr_q, rptr_d;
    state_t           state_q, state_d;
    logic [PORTW-1:0] port_q, port_d;
    logic             credit_q;

    logic [EW-1:0]    head;
    logic [1:0]       head_type;
    logic             empty, full, pop, push, head_is_hd;

    assign head       = mem_q[rptr_q[AW-1:0]];
    assign head_type  = head[DATAW-1 -: 2];
    assign empty      = (wptr_q == rptr_q);
    assign full       = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign pop        = !empty && ordy;
    assign push       = ivalid && (!full || pop);
    assign head_is_hd = !empty && (head_type == TYPE_HEAD);

    // Storage is not reset; stale entries are masked by the empty check below.
    assign ovalid  = !empty;
    assign odata   = empty ? '0 : head[DATAW-1:0];
    assign ovch    = empty ? '0 : head[DATAW +: VCHW];
    assign ocount  = wptr_q - rptr_q;
    assign ocredit = credit_q;
    assign oreq    = (state_q == S_ACTIVE) || head_is_hd;
    assign oport   = (state_q == S_ACTIVE) ? port_q :
                     (head_is_hd ? head[PORTW-1:0] : '0);

    always_comb begin
        wptr_d  = push ? wptr_q + PTR_ONE : wptr_q;
        rptr_d  = pop  ? rptr_q + PTR_ONE : rptr_q;
        state_d = state_q;
        port_d  = port_q;
        if (pop) begin
            if (head_type == TYPE_HEAD) begin
                state_d = S_ACTIVE;
                port_d  = head[PORTW-1:0];
            end else if (head_type == TYPE_TAIL) begin
                state_d = S_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q[AW-1:0]] <= {ivch, idata};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            state_q  <= S_IDLE;
            port_q   <= '0;
            credit_q <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            state_q  <= state_d;
            port_q   <= port_d;
            credit_q <= pop;
        end
    end

`ifdef IB_ERR_CHECK_EN
    localparam logic [1:0] TYPE_NONE = 2'd0;
    logic err_q, err_d;

    // Sticky: dropped write, body/tail without a packet open, or a head inside an open packet.
    always_comb begin
        err_d = err_q
              | (ivalid && full && !pop)
              | (pop && (state_q == S_IDLE) && (head_type != TYPE_NONE) && (head_type != TYPE_HEAD))
              | (pop && (state_q == S_ACTIVE) && (head_type == TYPE_HEAD));
    end

    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end

    assign oerr = err_q;
`else
    assign oerr = 1'b0;
`endif
endmodule

// File: tb/tb_ib_fifo.sv
// Randomized and directed bench for ib_fifo against a queue-based packet model.
module tb_ib_fifo;
    localparam int DATAW = 66;
    localparam int DEPTH = 4;
    localparam logic [1:0] T_NONE = 2'd0, T_HEAD = 2'd1, T_DATA = 2'd2, T_TAIL = 2'd3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [DATAW-1:0] idata = '0;
    logic             ivalid = 1'b0;
    logic [0:0]       ivch = '0;
    logic [DATAW-1:0] odata;
    logic             ovalid;
    logic [0:0]       ovch;
    logic             ordy = 1'b0;
    logic             ocredit;
    logic             oreq;
    logic [0:0]       oport;
    logic [2:0]       ocount;
    logic             oerr;

    ib_fifo #(.DATAW(DATAW), .VCHW(1), .DEPTH(DEPTH), .PORTW(1)) dut (
        .clk(clk), .rst(rst), .idata(idata), .ivalid(ivalid), .ivch(ivch),
        .odata(odata), .ovalid(ovalid), .ovch(ovch), .ordy(ordy),
        .ocredit(ocredit), .oreq(oreq), .oport(oport), .ocount(ocount), .oerr(oerr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int credit_cnt = 0;
    bit chk_en = 1'b0;

    // Model: flits in arrival order plus packet-open flag, latched port, credit and error.
    logic [DATAW:0] q[$];
    bit             m_active = 0;
    bit             m_port = 0;
    bit             m_credit = 0;
    bit             m_err = 0;

    task automatic chk(input string name, input logic [DATAW:0] act, input logic [DATAW:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit v, input logic [DATAW-1:0] d, input bit vc, input bit r, input bit rs);
        bit pop, full;
        logic [DATAW:0] f;
        if (rs) begin
            q.delete();
            m_active = 0; m_port = 0; m_credit = 0; m_err = 0;
            return;
        end
        pop  = (q.size() > 0) && r;
        full = (q.size() == DEPTH);
        if (pop) begin
            f = q.pop_front();
            case (f[65:64])
                T_HEAD: begin if (m_active) m_err = 1; m_active = 1; m_port = f[0]; end
                T_TAIL: begin if (!m_active) m_err = 1; m_active = 0; end
                T_DATA: begin if (!m_active) m_err = 1; end
                default: ;
            endcase
        end
        m_credit = pop;
        if (v && (!full || pop)) q.push_back({vc, d});
        else if (v) m_err = 1;
    endtask

    task automatic cycle(input bit v, input logic [DATAW-1:0] d, input bit vc, input bit r, input bit rs);
        ivalid = v; idata = d; ivch = vc; ordy = r; rst = rs;
        @(posedge clk);
        model_step(v, d, vc, r, rs);
        @(negedge clk);
    endtask

    function automatic logic [DATAW-1:0] flit(input logic [1:0] t, input logic [63:0] p);
        return {t, p};
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            bit hh;
            hh = (q.size() > 0) && (q[0][65:64] == T_HEAD);
            if (ocredit === 1'b1) credit_cnt++;
            chk("ovalid", ovalid, q.size() > 0);
            chk("odata",  odata,  q.size() > 0 ? q[0][DATAW-1:0] : '0);
            chk("ovch",   ovch,   q.size() > 0 ? q[0][DATAW] : 1'b0);
            chk("ocount", ocount, q.size());
            chk("ocredit", ocredit, m_credit);
            chk("oreq",   oreq,   m_active || hh);
            chk("oport",  oport,  m_active ? m_port : (hh ? q[0][0] : 1'b0));
`ifdef IB_ERR_CHECK_EN
            chk("oerr",   oerr,   m_err);
`else
            chk("oerr",   oerr,   1'b0);
`endif
        end
    end

    initial begin
        // Reset then idle
        cycle(0, '0, 0, 0, 1);
        cycle(0, '0, 0, 0, 1);
        chk_en = 1'b1;
        chk("rst_outputs", {odata, ovalid, ovch, ocredit, oreq, oport, ocount, oerr}, '0);
        for (int i = 0; i < 10; i++) begin
            cycle(0, '0, 0, 0, 0);
            chk("idle_ovalid", ovalid, 1'b0);
        end

        // Single packet: HEAD(9), 20 DATA, TAIL with ordy high
        credit_cnt = 0;
        cycle(1, flit(T_HEAD, 64'h09), 0, 1, 0);
        chk("pkt_ovalid_rise", ovalid, 1'b1);
        chk("pkt_oport_head", oport, 1'b1);
        for (int i = 0; i < 20; i++) begin
            cycle(1, flit(T_DATA, 64'(i + 100)), 1, 1, 0);
            chk("pkt_oport_mid", {oreq, oport}, 2'b11);
        end
        cycle(1, flit(T_TAIL, 64'hAB), 0, 1, 0);
        chk("pkt_oport_tail", {oreq, oport}, 2'b11);
        for (int i = 0; i < 3; i++) cycle(0, '0, 0, 1, 0);
        chk("pkt_credits", credit_cnt, 22);
        chk("pkt_oreq_after", oreq, 1'b0);

        // Fill and stall
        cycle(0, '0, 0, 0, 1);
        for (int i = 0; i < 4; i++) cycle(1, flit(T_DATA, 64'(i)), 0, 0, 0);
        chk("fill_count", ocount, 3'd4);
        cycle(1, flit(T_DATA, 64'h55), 0, 0, 0);
        chk("drop_count", ocount, 3'd4);
`ifdef IB_ERR_CHECK_EN
        chk("drop_oerr", oerr, 1'b1);
`else
        chk("drop_oerr", oerr, 1'b0);
`endif

        // Full with simultaneous read/write
        cycle(0, '0, 0, 0, 1);
        for (int i = 0; i < 4; i++) cycle(1, flit(T_NONE, 64'(i + 7)), 0, 0, 0);
        cycle(1, flit(T_NONE, 64'h77), 1, 1, 0);
        chk("fullrw_count", ocount, 3'd4);
        chk("fullrw_oerr", oerr, 1'b0);
        chk("fullrw_head", odata, flit(T_NONE, 64'd8));

        // Mid-packet underrun: HEAD(4), 2 DATA, gap, TAIL
        cycle(0, '0, 0, 0, 1);
        cycle(1, flit(T_HEAD, 64'h04), 0, 1, 0);
        cycle(1, flit(T_DATA, 64'h1), 0, 1, 0);
        cycle(1, flit(T_DATA, 64'h2), 0, 1, 0);
        cycle(0, '0, 0, 1, 0);
        for (int i = 0; i < 5; i++) begin
            cycle(0, '0, 0, 1, 0);
            chk("gap_req_port", {ovalid, oreq, oport}, 3'b010);
        end
        cycle(1, flit(T_TAIL, 64'h3), 0, 1, 0);
        cycle(0, '0, 0, 1, 0);
        chk("gap_oreq_after", oreq, 1'b0);

        // Reset mid-packet with 3 flits stored
        cycle(0, '0, 0, 0, 1);
        cycle(1, flit(T_HEAD, 64'h1), 0, 0, 0);
        cycle(1, flit(T_DATA, 64'h2), 0, 1, 0);
        cycle(1, flit(T_DATA, 64'h3), 0, 0, 0);
        cycle(1, flit(T_TAIL, 64'h4), 0, 0, 0);
        chk("mid_pre_state", {oreq, ocount}, {1'b1, 3'd3});
        credit_cnt = 0;
        cycle(0, '0, 0, 1, 1);
        chk("mid_rst_state", {oreq, ovalid, ocount, ocredit}, '0);
        cycle(0, '0, 0, 1, 0);
        cycle(0, '0, 0, 1, 0);
        chk("mid_rst_credits", credit_cnt, 0);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            logic [63:0] p;
            p = {$urandom, $urandom};
            cycle($urandom_range(0, 3) != 0, flit(2'($urandom_range(0, 3)), p),
                  1'($urandom), $urandom_range(0, 2) != 0, $urandom_range(0, 299) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
